// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

  localparam logic ADEL_NONE  = 1'b0;
  localparam logic ADEL_FAULT = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; storage is not reset, only the pointers and count.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: sequential fetch, in-flight tracking, entry queue, redirect flush.
// Define FETCH_BUF_BYPASS_EN to let returning data reach IF in the same cycle when the queue is empty.
module inst_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_adel
);

  localparam int EC_W  = $clog2(DEPTH + 1);
  localparam int OC_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = ((EC_W > OC_W) ? EC_W : OC_W) + 1;

  logic [31:0]     fetch_pc;
  logic [31:0]     addr_q;
  logic            req_q;
  logic            kill_q;
  logic            halt;
  logic [OC_W-1:0] outstanding;
  logic [OC_W-1:0] discard;

  logic            accept, drop, keep, bypass, hold, adel_push;
  logic            ent_push, ent_push_eff, ent_pop, ent_full, ent_empty;
  logic [EC_W-1:0] ent_count, ent_count_n;
  fetch_entry_t    ent_din, ent_head, resp_entry, adel_entry, shown;
  logic            fq_push, fq_full, fq_empty;
  logic [31:0]     fq_head;
  logic [$clog2(MAX_OUTSTANDING+1)-1:0] fq_count;
  logic            fq_unused;

  logic [31:0]     fetch_pc_n;
  logic [OC_W-1:0] outstanding_n, discard_n;
  logic            halt_n, kill_n, req_n, issue_n;
  logic [31:0]     addr_n;

  assign accept = req_q && inst_addr_ok;
  assign drop   = inst_data_ok && (discard != '0);
  assign keep   = inst_data_ok && !drop && !fq_empty;
  assign hold   = req_q && !inst_addr_ok;

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = keep && ent_empty && !redirect;
`else
  assign bypass = 1'b0;
`endif

  // A misaligned PC becomes a single fault entry once the bus is quiet.
  assign adel_push = !halt && pc_misaligned(fetch_pc) && (outstanding == '0) &&
                     !req_q && !ent_full && !redirect;

  assign resp_entry = '{pc: fq_head, inst: inst_rdata, adel: ADEL_NONE};
  assign adel_entry = '{pc: fetch_pc, inst: 32'h0, adel: ADEL_FAULT};

  assign ent_push     = !redirect && ((keep && !(bypass && out_ready)) || adel_push);
  assign ent_din      = adel_push ? adel_entry : resp_entry;
  assign ent_pop      = !ent_empty && out_ready;
  assign ent_push_eff = ent_push && (!ent_full || ent_pop);
  assign fq_push      = accept && !kill_q && !redirect;
  assign fq_unused    = ^fq_count;

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_entry_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ent_push),
    .din   (ent_din),
    .pop   (ent_pop),
    .flush (redirect),
    .dout  (ent_head),
    .full  (ent_full),
    .empty (ent_empty),
    .count (ent_count)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pc_queue (
    .clk   (clk),
    .reset (reset),
    .push  (fq_push),
    .din   (fetch_pc),
    .pop   (keep),
    .flush (redirect),
    .dout  (fq_head),
    .full  (fq_full),
    .empty (fq_empty),
    .count (fq_count)
  );

  assign shown     = ent_empty ? resp_entry : ent_head;
  assign out_valid = !ent_empty || bypass;
  assign out_pc    = out_valid ? shown.pc   : 32'h0;
  assign out_inst  = out_valid ? shown.inst : 32'h0;
  assign out_adel  = out_valid ? shown.adel : 1'b0;

  assign inst_req  = req_q;
  assign inst_addr = addr_q;

  // Next request is decided from next-cycle occupancy so inst_req is a clean register.
  always_comb begin
    outstanding_n = outstanding + OC_W'(accept) - OC_W'(inst_data_ok);
    ent_count_n   = redirect ? '0 : ent_count + EC_W'(ent_push_eff) - EC_W'(ent_pop);
    fetch_pc_n    = fetch_pc;
    if (redirect)                fetch_pc_n = redirect_pc;
    else if (accept && !kill_q)  fetch_pc_n = fetch_pc + 32'd4;
    halt_n    = redirect ? 1'b0 : (halt || adel_push);
    discard_n = redirect ? outstanding_n
                         : discard - OC_W'(drop) + OC_W'(accept && kill_q);
    kill_n    = hold && (kill_q || redirect);
    issue_n   = !halt_n && !fq_full &&
                ((SUM_W'(ent_count_n) + SUM_W'(outstanding_n)) < SUM_W'(DEPTH)) &&
                (outstanding_n < OC_W'(MAX_OUTSTANDING)) &&
                !pc_misaligned(fetch_pc_n);
    req_n     = hold ? 1'b1 : issue_n;
    addr_n    = hold ? addr_q : fetch_pc_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      kill_q      <= 1'b0;
      halt        <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      fetch_pc    <= fetch_pc_n;
      addr_q      <= addr_n;
      req_q       <= req_n;
      kill_q      <= kill_n;
      halt        <= halt_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer with an in-order bus responder (inst = ~addr).
module tb_inst_fetch_buffer;

`ifdef FETCH_BUF_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_adel;

  logic        resp_en;
  logic [31:0] pend [$];
  int          n_checks;
  int          n_pass;

  logic [31:0] t1_pc   [4] = '{32'hbfc00000, 32'hbfc00004, 32'hbfc00008, 32'hbfc0000c};
  logic [31:0] t1_inst [4] = '{32'h403fffff, 32'h403ffffb, 32'h403ffff7, 32'h403ffff3};

  inst_fetch_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_adel     (out_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  // Responder bookkeeping: sees pre-edge values of the handshake.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend.delete();
    end else begin
      if (inst_data_ok && pend.size() > 0) void'(pend.pop_front());
      if (inst_req && inst_addr_ok) pend.push_back(inst_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    redirect     = 1'b0;
    inst_data_ok = resp_en && (pend.size() > 0);
    inst_rdata   = inst_data_ok ? mem_word(pend[0]) : 32'h0;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc,
                            input logic [31:0] inst, input logic adel);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_inst"}, out_inst, inst);
    check({tag, "_adel"}, 32'(out_adel), 32'(adel));
    tick();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
  endtask

  initial begin
    logic [31:0] head;
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    inst_addr_ok = 1'b1;
    inst_rdata   = 32'h0;
    inst_data_ok = 1'b0;
    out_ready    = 1'b1;
    resp_en      = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   32'(inst_req),  32'd0);
    check("rst_addr",  inst_addr,      32'hbfc00000);
    check("rst_vld",   32'(out_valid), 32'd0);
    check("rst_inst",  out_inst,       32'h0);
    check("rst_pc",    out_pc,         32'h0);
    check("rst_adel",  32'(out_adel),  32'd0);

    // Sequential fetch with one-cycle memory
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t1_req_c0", 32'(inst_req), 32'd0);
    tick();
    check("t1_req_c1",  32'(inst_req), 32'd1);
    check("t1_addr_c1", inst_addr,     32'hbfc00000);
    tick();
    check("t1_dok_c2", 32'(inst_data_ok), 32'd1);
    check("t1_vld_c2", 32'(out_valid),    32'(BYP));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t1_vld%0d", i),  32'(out_valid), 32'd1);
      check($sformatf("t1_pc%0d", i),   out_pc,   t1_pc[i + BYP]);
      check($sformatf("t1_inst%0d", i), out_inst, t1_inst[i + BYP]);
    end

    // Stall IF: buffer fills, requests stop, then drains in order
    head = 32'hbfc00008 + 32'(4 * BYP);
    out_ready = 1'b0;
    repeat (10) tick();
    check("t2_req_full", 32'(inst_req),  32'd0);
    check("t2_vld_full", 32'(out_valid), 32'd1);
    check("t2_head_pc",  out_pc,         head);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      expect_out($sformatf("t2_e%0d", i), head + 32'(4 * i), mem_word(head + 32'(4 * i)), 1'b0);

    // Redirect with two requests outstanding
    resp_en = 1'b0;
    repeat (8) tick();
    check("t3_vld_idle", 32'(out_valid), 32'd0);
    check("t3_req_cap",  32'(inst_req),  32'd0);
    do_redirect(32'h80001000);
    check("t3_addr_new", inst_addr,      32'h80001000);
    check("t3_vld_n1",   32'(out_valid), 32'd0);
    resp_en = 1'b1;
    expect_out("t3_first", 32'h80001000, 32'h7fffefff, 1'b0);

    // Redirect to a misaligned PC with entries queued
    out_ready = 1'b0;
    repeat (3) tick();
    check("t5_vld_pre", 32'(out_valid), 32'd1);
    do_redirect(32'h80000002);
    check("t5_vld_n1", 32'(out_valid), 32'd0);
    check("t5_req_n1", 32'(inst_req),  32'd0);
    out_ready = 1'b1;
    expect_out("t5_adel", 32'h80000002, 32'h0, 1'b1);
    repeat (4) tick();
    check("t5_halt_vld", 32'(out_valid), 32'd0);
    check("t5_halt_req", 32'(inst_req),  32'd0);

    // Redirect while a request is held unaccepted
    inst_addr_ok = 1'b0;
    do_redirect(32'h80001800);
    check("t4_req_hold",  32'(inst_req), 32'd1);
    check("t4_addr_hold", inst_addr,     32'h80001800);
    repeat (2) tick();
    do_redirect(32'h80002000);
    check("t4_req_kill",  32'(inst_req), 32'd1);
    check("t4_addr_kill", inst_addr,     32'h80001800);
    repeat (2) tick();
    check("t4_addr_stay", inst_addr, 32'h80001800);
    inst_addr_ok = 1'b1;
    tick();
    check("t4_addr_next", inst_addr,     32'h80002000);
    check("t4_req_next",  32'(inst_req), 32'd1);
    expect_out("t4_first", 32'h80002000, 32'h7fffdfff, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
